// File: rtl/vga_sync_core.sv
// Free-running VGA raster timing generator: sync pulses, beam position,
// registered active-video flag and a pixel-clock-domain frame counter.
module vga_sync_core #(
  parameter int   H_DISPLAY   = 640,
  parameter int   H_FRONT     = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BACK      = 48,
  parameter int   V_DISPLAY   = 480,
  parameter int   V_FRONT     = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BACK      = 33,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic [8:0] frame_no,
  output logic       line_end,
  output logic       frame_end
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_size_check
    $error("vga_sync_core: H_TOTAL and V_TOTAL must fit in 10 bits");
  end

  localparam logic [9:0]  H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_DISP_W     = 11'(H_DISPLAY);
  localparam logic [10:0] V_DISP_W     = 11'(V_DISPLAY);
  localparam logic [10:0] H_SYNC_BEG_W = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] H_SYNC_END_W = 11'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [10:0] V_SYNC_BEG_W = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] V_SYNC_END_W = 11'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic        DISP_AT_ORIGIN = (H_DISPLAY > 0) && (V_DISPLAY > 0);

  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic [8:0] frame_q, frame_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       disp_q, disp_d;
  logic [10:0] hpos_dw, vpos_dw;

  always_comb begin
    hpos_d  = hpos_q;
    vpos_d  = vpos_q;
    frame_d = frame_q;
    if (pix_en) begin
      if (hpos_q == H_LAST) begin
        hpos_d = '0;
        if (vpos_q == V_LAST) begin
          vpos_d  = '0;
          frame_d = frame_q + 9'd1;
        end else begin
          vpos_d = vpos_q + 10'd1;
        end
      end else begin
        hpos_d = hpos_q + 10'd1;
      end
    end
  end

  // Sync and blanking are decoded from the next position so they line up
  // with the counters they describe once registered.
  assign hpos_dw = {1'b0, hpos_d};
  assign vpos_dw = {1'b0, vpos_d};
  assign hsync_d = (hpos_dw >= H_SYNC_BEG_W && hpos_dw < H_SYNC_END_W) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign vsync_d = (vpos_dw >= V_SYNC_BEG_W && vpos_dw < V_SYNC_END_W) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign disp_d  = (hpos_dw < H_DISP_W) && (vpos_dw < V_DISP_W);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hpos_q  <= '0;
      vpos_q  <= '0;
      frame_q <= '0;
      hsync_q <= ~SYNC_ACTIVE;
      vsync_q <= ~SYNC_ACTIVE;
      disp_q  <= DISP_AT_ORIGIN;
    end else begin
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      frame_q <= frame_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      disp_q  <= disp_d;
    end
  end

  assign hpos       = hpos_q;
  assign vpos       = vpos_q;
  assign frame_no   = frame_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign display_on = disp_q;
  assign line_end   = pix_en && (hpos_q == H_LAST);
  assign frame_end  = line_end && (vpos_q == V_LAST);

endmodule

// File: tb/tb_vga_sync_core.sv
// Directed self-checking bench: default 640x480 timing instance plus a tiny
// 8x4 positive-sync instance used for vertical timing and frame wrap.
module tb_vga_sync_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic pix_en;

  logic       hsyncA, vsyncA, dispA, lineEndA, frameEndA;
  logic [9:0] hposA, vposA;
  logic [8:0] frameA;

  logic       hsyncB, vsyncB, dispB, lineEndB, frameEndB;
  logic [9:0] hposB, vposB;
  logic [8:0] frameB;

  int testsRun = 0;
  int testsFailed = 0;

  int cnt, first, last, leCnt, lePos, feCnt, feH, feV, d639, d640, leOff, changes, hsCnt;

  vga_sync_core dutA (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hsync(hsyncA), .vsync(vsyncA), .display_on(dispA),
    .hpos(hposA), .vpos(vposA), .frame_no(frameA),
    .line_end(lineEndA), .frame_end(frameEndA)
  );

  vga_sync_core #(
    .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(1), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SYNC_ACTIVE(1'b1)
  ) dutB (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .hsync(hsyncB), .vsync(vsyncB), .display_on(dispB),
    .hpos(hposB), .vpos(vposB), .frame_no(frameB),
    .line_end(lineEndB), .frame_end(frameEndB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    pix_en = 1'b1;
    repeat (4) tick();
    checkOutput("rst_hpos", 32'(hposA), 0);
    checkOutput("rst_vpos", 32'(vposA), 0);
    checkOutput("rst_frame", 32'(frameA), 0);
    checkOutput("rst_hsync", 32'(hsyncA), 1);
    checkOutput("rst_vsync", 32'(vsyncA), 1);
    checkOutput("rst_disp", 32'(dispA), 1);
    checkOutput("rst_line_end", 32'(lineEndA), 0);
    checkOutput("rst_frame_end", 32'(frameEndA), 0);
    checkOutput("rstB_hsync", 32'(hsyncB), 0);
    checkOutput("rstB_vsync", 32'(vsyncB), 0);
    checkOutput("rstB_disp", 32'(dispB), 1);

    rst_n = 1'b1;
    tick();
    checkOutput("release_hpos", 32'(hposA), 1);
    checkOutput("releaseB_hpos", 32'(hposB), 1);

    // One full line on the default timing.
    leCnt = 0; lePos = -1; hsCnt = 0; first = -1; last = -1; d639 = -1; d640 = -1;
    repeat (799) begin
      if (lineEndA) begin leCnt++; lePos = int'(hposA); end
      tick();
      if (hsyncA == 1'b0) begin
        if (first < 0) first = int'(hposA);
        last = int'(hposA);
        hsCnt++;
      end
      if (hposA == 10'd639) d639 = int'(dispA);
      if (hposA == 10'd640) d640 = int'(dispA);
    end
    checkOutput("h_hsync_width", 32'(hsCnt), 96);
    checkOutput("h_hsync_first", 32'(first), 656);
    checkOutput("h_hsync_last", 32'(last), 751);
    checkOutput("h_line_end_cnt", 32'(leCnt), 1);
    checkOutput("h_line_end_pos", 32'(lePos), 799);
    checkOutput("h_disp_639", 32'(d639), 1);
    checkOutput("h_disp_640", 32'(d640), 0);
    checkOutput("h_wrap_hpos", 32'(hposA), 0);
    checkOutput("h_wrap_vpos", 32'(vposA), 1);

    // One full frame on the small instance, starting at the release edge.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cnt = 0; first = -1; last = -1; feCnt = 0; feH = -1; feV = -1; hsCnt = 0;
    repeat (32) begin
      if (frameEndB) begin feCnt++; feH = int'(hposB); feV = int'(vposB); end
      tick();
      if (vsyncB == 1'b1) begin
        if (first < 0) first = int'(vposB) * 16 + int'(hposB);
        last = int'(vposB) * 16 + int'(hposB);
        cnt++;
      end
      if (hsyncB == 1'b1) hsCnt++;
    end
    checkOutput("v_vsync_width", 32'(cnt), 8);
    checkOutput("v_vsync_first", 32'(first), 2 * 16 + 0);
    checkOutput("v_vsync_last", 32'(last), 2 * 16 + 7);
    checkOutput("v_hsync_total", 32'(hsCnt), 8);
    checkOutput("v_frame_end_cnt", 32'(feCnt), 1);
    checkOutput("v_frame_end_h", 32'(feH), 7);
    checkOutput("v_frame_end_v", 32'(feV), 3);
    checkOutput("v_wrap_hpos", 32'(hposB), 0);
    checkOutput("v_wrap_vpos", 32'(vposB), 0);
    checkOutput("v_frame_no", 32'(frameB), 1);
    checkOutput("v_A_hpos_32", 32'(hposA), 32);

    // Drive the small instance to frame 511, then across the wrap.
    repeat (510 * 32) tick();
    checkOutput("wrap_frame_511", 32'(frameB), 511);
    repeat (31) tick();
    checkOutput("wrap_frame_end", 32'(frameEndB), 1);
    tick();
    checkOutput("wrap_frame_0", 32'(frameB), 0);
    checkOutput("wrap_hpos", 32'(hposB), 0);
    checkOutput("wrap_vpos", 32'(vposB), 0);

    // Clock enable toggling on the default instance.
    rst_n = 1'b0;
    tick();
    rst_n  = 1'b1;
    pix_en = 1'b0;
    tick();
    checkOutput("ce_release_hold", 32'(hposA), 0);
    leCnt = 0; leOff = 0;
    for (int j = 0; j < 1600; j++) begin
      pix_en = (j % 2 == 0);
      #1;
      if (lineEndA) leCnt++;
      if (!pix_en && hposA == 10'd799 && lineEndA) leOff++;
      tick();
      if (j == 3) checkOutput("ce_half_rate", 32'(hposA), 2);
    end
    checkOutput("ce_line_end_cnt", 32'(leCnt), 1);
    checkOutput("ce_line_end_off", 32'(leOff), 0);
    checkOutput("ce_hpos", 32'(hposA), 0);
    checkOutput("ce_vpos", 32'(vposA), 1);

    pix_en = 1'b0;
    changes = 0;
    repeat (100) begin
      tick();
      if (hposA !== 10'd0 || vposA !== 10'd1 || hsyncA !== 1'b1 || vsyncA !== 1'b1 ||
          dispA !== 1'b1 || frameA !== 9'd0 || lineEndA !== 1'b0 || frameEndA !== 1'b0)
        changes++;
    end
    checkOutput("freeze_changes", 32'(changes), 0);

    // Mid-frame reset while the small instance is inside vsync.
    rst_n  = 1'b0;
    pix_en = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (22) tick();
    checkOutput("mid_pre_vsync", 32'(vsyncB), 1);
    checkOutput("mid_pre_hpos", 32'(hposB), 6);
    checkOutput("mid_pre_vpos", 32'(vposB), 2);
    rst_n = 1'b0;
    tick();
    checkOutput("mid_hpos", 32'(hposB), 0);
    checkOutput("mid_vpos", 32'(vposB), 0);
    checkOutput("mid_vsync", 32'(vsyncB), 0);
    checkOutput("mid_hsync", 32'(hsyncB), 0);
    checkOutput("mid_disp", 32'(dispB), 1);
    checkOutput("midA_hpos", 32'(hposA), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/vga_sync_core.md
# vga_sync_core

Free-running VGA raster timing generator with a built-in frame counter. It sits directly upstream of the pixel/pattern logic in the top-level demo and supplies the sync pulses, the beam position, the active-video flag and a synchronous frame number. The frame number is advanced from the pixel clock domain, so downstream logic never needs to clock on a sync edge. Default timing is 640x480 @ 60 Hz from a 25.175 MHz (nominal 25 MHz) pixel clock.

## Interface
Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, logic level of hsync/vsync while asserted (0 = negative polarity)

Ports:
- clk  in  1  pixel clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- pix_en  in  1  clock enable; counters advance only on cycles with pix_en=1
- hsync  out  1  horizontal sync, polarity per SYNC_ACTIVE
- vsync  out  1  vertical sync, polarity per SYNC_ACTIVE
- display_on  out  1  high when (hpos, vpos) is inside the visible area
- hpos  out  10  current column, 0..H_TOTAL-1
- vpos  out  10  current line, 0..V_TOTAL-1
- frame_no  out  9  frame counter, wraps modulo 512
- line_end  out  1  one-cycle strobe: last pixel of a line, being consumed this cycle
- frame_end  out  1  one-cycle strobe: last pixel of a frame, being consumed this cycle

## Operation
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525). Both must fit in 10 bits; elaboration error otherwise.
- Horizontal counter hpos: on pix_en, hpos <= (hpos == H_TOTAL-1) ? 0 : hpos+1.
- Vertical counter vpos: advances only on pix_en with hpos == H_TOTAL-1; vpos <= (vpos == V_TOTAL-1) ? 0 : vpos+1.
- frame_no increments by 1 (mod 512) on pix_en with hpos == H_TOTAL-1 and vpos == V_TOTAL-1, i.e. at the same edge hpos/vpos wrap to 0,0.
- hsync asserted (= SYNC_ACTIVE) iff H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC (656..751 default); otherwise ~SYNC_ACTIVE.
- vsync asserted iff V_DISPLAY+V_FRONT <= vpos < V_DISPLAY+V_FRONT+V_SYNC (490..491 default); otherwise ~SYNC_ACTIVE.
- display_on = (hpos < H_DISPLAY) && (vpos < V_DISPLAY).
- hsync, vsync, display_on are registered: computed from the next-state counter values so they change on the same edge as hpos/vpos and always describe the currently presented position. No combinational path from pix_en or counters to these outputs.
- line_end = pix_en && hpos == H_TOTAL-1; frame_end = line_end && vpos == V_TOTAL-1. Combinational decodes of registered state plus pix_en; a held-low pix_en suppresses them.
- pix_en=0: all registers hold; outputs static.

## Timing
- Reset (rst_n=0 at a rising edge, overrides pix_en): hpos=0, vpos=0, frame_no=0, hsync=~SYNC_ACTIVE, vsync=~SYNC_ACTIVE, display_on=1 (position 0,0 is visible). line_end/frame_end=0 while in reset state at hpos=0.
- Reset mid-frame: takes effect on the next edge regardless of position; no partial sync pulse is extended.
- First edge after reset release with pix_en=1: hpos=1.
- Line period = H_TOTAL pix_en cycles; frame period = H_TOTAL*V_TOTAL pix_en cycles (420000 default).
- hsync width exactly H_SYNC enabled cycles; vsync width exactly V_SYNC*H_TOTAL enabled cycles, starting on the edge where hpos becomes 0 and vpos becomes V_DISPLAY+V_FRONT.
- frame_no 511 -> 0 wrap at frame end; no sticky/overflow flag.

## Test plan
- Reset: hold rst_n=0 4 cycles with pix_en=1 -> hpos=0, vpos=0, frame_no=0, hsync=vsync=1, display_on=1; release -> hpos=1 after one edge.
- Horizontal: run 800 enabled cycles from reset -> hpos 639->640 drops display_on; hsync low for hpos 656..751 (96 cycles); line_end high only at hpos=799; hpos=0, vpos=1 after cycle 800.
- Vertical/frame: run 420000 cycles -> vsync low exactly 1600 cycles from (0,490) to (799,491); frame_end single pulse at (799,524); next edge hpos=0, vpos=0, frame_no=1.
- Clock enable: alternate pix_en 1/0 -> counters advance every other cycle, strobes only on enabled cycles; line period 1600 clk; pix_en=0 for 100 cycles freezes all outputs.
- Wrap: force 512 frames (or preload via short-parameter build H=8/V=4 totals) -> frame_no 511 -> 0; SYNC_ACTIVE=1 build gives positive-going hsync/vsync with identical timing.
- Mid-frame reset: assert rst_n=0 at (700,491) with vsync asserted -> next edge all outputs at reset values, vsync deasserted.
